// File: rtl/mpc_dbg_cmd_router.sv
// System-clock-side debug command router: syncs TCK-domain update events and delivers each command
// to one of NUM_CORES channels with valid/ack handshake. Optional broadcast: MPC_DBG_BROADCAST_EN.
module mpc_dbg_cmd_router #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned SR_WIDTH       = 38,
  parameter int unsigned IR_WIDTH       = 2,
  parameter int unsigned SEL_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic [IR_WIDTH-1:0]  ir_in,
  input  logic [SR_WIDTH-1:0]  sr,
  input  logic [SEL_WIDTH-1:0] core_sel,
  input  logic [NUM_CORES-1:0] cmd_ack,
  input  logic                 err_clr,
  output logic [SR_WIDTH-1:0]  jdo,
  output logic [IR_WIDTH-1:0]  cmd_ir,
  output logic [NUM_CORES-1:0] cmd_valid,
  output logic                 ir_strobe,
  output logic                 busy,
  output logic                 err_overrun,
  output logic                 err_timeout,
  output logic                 err_badsel
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [2:0]           udr_sync_q, uir_sync_q;
  logic                 udr_evt_q, ir_strobe_q;
  logic [1:0]           state_q, state_d;
  logic [SR_WIDTH-1:0]  jdo_q, jdo_d;
  logic [IR_WIDTH-1:0]  cmd_ir_q, cmd_ir_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic                 bcast_q, bcast_d;
  logic [NUM_CORES-1:0] valid_q, valid_d, sel_onehot;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 err_ov_q, err_to_q, err_bs_q;
  logic                 set_ov, set_to, set_bs;
  logic                 sel_in_range, sel_bcast;

  assign sel_in_range = 32'(core_sel) < NUM_CORES;

`ifdef MPC_DBG_BROADCAST_EN
  assign sel_bcast = (core_sel == '1);
`else
  assign sel_bcast = 1'b0;
`endif

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      sel_onehot[i] = (sel_q == SEL_WIDTH'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    jdo_d    = jdo_q;
    cmd_ir_d = cmd_ir_q;
    sel_d    = sel_q;
    bcast_d  = bcast_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    set_ov   = 1'b0;
    set_to   = 1'b0;
    set_bs   = 1'b0;
    case (state_q)
      StIdle: begin
        if (udr_evt_q) begin
          jdo_d    = sr;
          cmd_ir_d = ir_in;
          sel_d    = core_sel;
          bcast_d  = sel_bcast;
          if (sel_in_range || sel_bcast) begin
            state_d = StIssue;
          end else begin
            set_bs = 1'b1;
          end
        end
      end
      StIssue: begin
        valid_d = bcast_q ? '1 : sel_onehot;
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (valid_q == '0) begin
          state_d = StIdle;
        end else begin
          valid_d = valid_q & ~cmd_ack;
          cnt_d   = cnt_q + CntW'(1);
          // An ack that empties the set on the deadline cycle beats the timeout.
          if ((TIMEOUT_CYCLES != 0) && (valid_d != '0) &&
              (cnt_q == CntW'(TIMEOUT_CYCLES - 1))) begin
            valid_d = '0;
            set_to  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (udr_evt_q && (state_q != StIdle)) begin
      set_ov = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_q  <= '0;
      uir_sync_q  <= '0;
      udr_evt_q   <= 1'b0;
      ir_strobe_q <= 1'b0;
      state_q     <= StIdle;
      jdo_q       <= '0;
      cmd_ir_q    <= '0;
      sel_q       <= '0;
      bcast_q     <= 1'b0;
      valid_q     <= '0;
      cnt_q       <= '0;
      err_ov_q    <= 1'b0;
      err_to_q    <= 1'b0;
      err_bs_q    <= 1'b0;
    end else begin
      udr_sync_q  <= {udr_sync_q[1:0], vs_udr};
      uir_sync_q  <= {uir_sync_q[1:0], vs_uir};
      udr_evt_q   <= udr_sync_q[1] & ~udr_sync_q[2];
      ir_strobe_q <= uir_sync_q[1] & ~uir_sync_q[2];
      state_q     <= state_d;
      jdo_q       <= jdo_d;
      cmd_ir_q    <= cmd_ir_d;
      sel_q       <= sel_d;
      bcast_q     <= bcast_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      err_ov_q    <= set_ov | (err_ov_q & ~err_clr);
      err_to_q    <= set_to | (err_to_q & ~err_clr);
      err_bs_q    <= set_bs | (err_bs_q & ~err_clr);
    end
  end

  assign jdo         = jdo_q;
  assign cmd_ir      = cmd_ir_q;
  assign cmd_valid   = valid_q;
  assign ir_strobe   = ir_strobe_q;
  assign busy        = (state_q != StIdle);
  assign err_overrun = err_ov_q;
  assign err_timeout = err_to_q;
  assign err_badsel  = err_bs_q;

endmodule

// File: doc/mpc_dbg_cmd_router.md
# mpc_dbg_cmd_router

- Parametrised system-clock-side command router for the multi-core debug path.
- Detects update-DR / update-IR events coming from the virtual JTAG (TCK) domain and captures the shifted data register and instruction.
- Delivers each command to exactly one of NUM_CORES debug channels (or all of them, see Configuration) and holds it there with a valid/ack handshake, a timeout and sticky error reporting.
- Generalises the single-core sysclk take-action logic to N cores, so one JTAG node can serve the whole MPC platform.

## Interface
Parameters:
- NUM_CORES, 4: number of debug channels, 1..16.
- SR_WIDTH, 38: width of captured shift register / jdo.
- IR_WIDTH, 2: width of virtual IR.
- SEL_WIDTH, 4: width of core select field; must satisfy 2**SEL_WIDTH >= NUM_CORES+1.
- TIMEOUT_CYCLES, 1023: ack timeout in clk cycles; 0 disables timeout.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- vs_udr  in  1  update-DR level from TCK domain, asynchronous to clk.
- vs_uir  in  1  update-IR level from TCK domain, asynchronous to clk.
- ir_in  in  IR_WIDTH  virtual IR; stable around udr/uir.
- sr  in  SR_WIDTH  shift register contents; stable around udr.
- core_sel  in  SEL_WIDTH  target channel; stable around udr.
- cmd_ack  in  NUM_CORES  per-channel acknowledge; one-cycle pulse.
- err_clr  in  1  clears all sticky error flags.
- jdo  out  SR_WIDTH  captured command payload.
- cmd_ir  out  IR_WIDTH  captured IR for the current command.
- cmd_valid  out  NUM_CORES  per-channel command-pending level.
- ir_strobe  out  1  one-cycle pulse per update-IR event.
- busy  out  1  high while any command is outstanding.
- err_overrun  out  1  sticky: udr event arrived while busy.
- err_timeout  out  1  sticky: ack not received within TIMEOUT_CYCLES.
- err_badsel  out  1  sticky: core_sel out of range.

## Operation
Synchronisers:
- vs_udr and vs_uir each pass through 3 flops (s1, s2, s3).
- The event pulse is s2 & ~s3.

FSM states IDLE, ISSUE, WAIT_ACK:
- IDLE, udr event:
  - Register jdo <= sr, cmd_ir <= ir_in, sel <= core_sel.
  - If sel < NUM_CORES: go to ISSUE.
  - Otherwise: set err_badsel and stay in IDLE; jdo is still updated.
- ISSUE (one cycle):
  - cmd_valid[sel] <= 1, timeout counter <= 0.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - cmd_ack[i] clears cmd_valid[i]; acks on channels whose cmd_valid is low are ignored.
  - When all cmd_valid are low, go to IDLE.
  - Counter increments each cycle. On reaching TIMEOUT_CYCLES (if nonzero): clear all cmd_valid, set err_timeout, go to IDLE.
  - Ack and timeout in the same cycle: the ack wins, no error.
- udr event in ISSUE or WAIT_ACK: set err_overrun and drop the event; jdo and cmd_ir are unchanged.

Other rules:
- busy = (state != IDLE).
- ir_strobe pulses on every uir event, in any state, and does not affect the FSM.
- err_clr and an error-setting event in the same cycle: the set wins.
- Reset mid-command: all outputs return to reset values at the next edge. No ack is awaited and no error is flagged.

## Timing
- Reset values:
  - jdo = 0, cmd_ir = 0, cmd_valid = 0.
  - ir_strobe = 0, busy = 0.
  - All error flags = 0.
  - Synchroniser flops = 0.
- udr sampled high first at edge E:
  - Event pulse is true after E+2.
  - jdo, cmd_ir and busy update at E+3.
  - cmd_valid rises at E+4.
- Ack latency:
  - cmd_ack high at edge A clears cmd_valid at A.
  - busy drops at A+1.
- ir_strobe is high for exactly the cycle after E+2 (uir).
- Minimum udr spacing for loss-free operation: ack latency + 5 cycles.

## Configuration
- MPC_DBG_BROADCAST_EN defined:
  - core_sel = all-ones (2**SEL_WIDTH-1) is broadcast: ISSUE sets every cmd_valid.
  - WAIT_ACK collects all NUM_CORES acks; timeout applies to the whole set.
- MPC_DBG_BROADCAST_EN not defined: all-ones is an ordinary out-of-range value and sets err_badsel.

## Test plan
- Unicast: NUM_CORES=4, sr=38'h2A_1234_5678, core_sel=2, udr pulse; ack at 5 cycles -> jdo=38'h2A_1234_5678 at E+3, cmd_valid=4'b0100 from E+4 to the ack edge, no errors.
- Timeout: TIMEOUT_CYCLES=8, core_sel=1, no ack -> cmd_valid[1] is high for exactly 8 cycles, err_timeout=1, busy=0; err_clr then clears it.
- Overrun: second udr event while waiting for ack -> err_overrun=1; jdo keeps the first payload; the first command completes normally.
- Bad select: core_sel=5 with NUM_CORES=4 -> err_badsel=1, cmd_valid stays 0, busy stays 0.
- Broadcast (macro defined): core_sel=4'hF -> cmd_valid=4'b1111; acks on cores 0,3,1,2 on separate cycles clear bits individually; busy falls one cycle after the last ack. Without the macro -> err_badsel=1.
- Reset mid-WAIT_ACK plus uir: reset asserted while cmd_valid=4'b0001 -> all outputs are 0 next cycle; a subsequent uir event gives exactly one ir_strobe pulse.
